// File: rtl/axi4lite_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_master_arbiter_if
//  Description : Requester-side and AXI4-Lite master-side signal bundle for
//                the two-requester AXI4-Lite arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4lite_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Requester side
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*STRB_W-1:0] req_wstrb;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [1:0]          rsp_resp;

    // AXI4-Lite bus
    logic                AWVALID;
    logic                AWREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic                WVALID;
    logic                WREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [STRB_W-1:0]   WSTRB;
    logic                BVALID;
    logic                BREADY;
    logic [1:0]          BRESP;
    logic                ARVALID;
    logic                ARREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                RVALID;
    logic                RREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;

    // Arbiter view: AXI master, requester target
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    // Environment view: requesters plus AXI slave
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_master_arbiter
//  Description : Round-robin arbiter funnelling two requesters onto a single
//                AXI4-Lite master port, one transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire                       ACLK,
    input  wire                       ARESET,
    axi4lite_master_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_last;
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_aw_done;
    logic                r_w_done;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_resp;

    logic                w_both;
    logic                w_gnt_idx;
    logic                w_gnt_write;
    logic                w_grant;
    logic [1:0]          w_req_ready;
    logic [1:0]          w_rsp_valid;
    logic                w_awvalid;
    logic                w_wvalid;
    logic                w_bready;
    logic                w_arvalid;
    logic                w_rready;

    // On contention the requester not granted last wins; otherwise the lone requester.
    assign w_both      = bus.req_valid[0] & bus.req_valid[1];
    assign w_gnt_idx   = w_both ? ~r_last : bus.req_valid[1];
    assign w_gnt_write = w_gnt_idx ? bus.req_write[1] : bus.req_write[0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) begin
                    w_grant     = 1'b1;
                    w_req_ready = w_gnt_idx ? 2'b10 : 2'b01;
                    w_next      = w_gnt_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
                if ((r_aw_done || bus.AWREADY) && (r_w_done || bus.WREADY)) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (bus.BVALID) begin
                    w_next = DONE;
                end
            end
            RD_REQ: begin
                w_arvalid = 1'b1;
                if (bus.ARREADY) begin
                    w_next = RD_RESP;
                end
            end
            RD_RESP: begin
                w_rready = 1'b1;
                if (bus.RVALID) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_rsp_valid = r_gnt ? 2'b10 : 2'b01;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            if (w_grant) begin
                r_gnt     <= w_gnt_idx;
                r_last    <= w_gnt_idx;
                r_addr    <= w_gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
                r_wdata   <= w_gnt_idx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
                r_wstrb   <= w_gnt_idx ? bus.req_wstrb[2*STRB_W-1:STRB_W] : bus.req_wstrb[STRB_W-1:0];
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                // Writes report zero read data; reads overwrite this on R.
                r_rdata   <= '0;
            end
            if (w_awvalid && bus.AWREADY) begin
                r_aw_done <= 1'b1;
            end
            if (w_wvalid && bus.WREADY) begin
                r_w_done <= 1'b1;
            end
            if (w_bready && bus.BVALID) begin
                r_resp <= bus.BRESP;
            end
            if (w_rready && bus.RVALID) begin
                r_rdata <= bus.RDATA;
                r_resp  <= bus.RRESP;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_resp  = r_resp;

    assign bus.AWVALID   = w_awvalid;
    assign bus.AWADDR    = r_addr;
    assign bus.WVALID    = w_wvalid;
    assign bus.WDATA     = r_wdata;
    assign bus.WSTRB     = r_wstrb;
    assign bus.BREADY    = w_bready;
    assign bus.ARVALID   = w_arvalid;
    assign bus.ARADDR    = r_addr;
    assign bus.RREADY    = w_rready;

endmodule
`default_nettype wire
